// File: rtl/eve_parent_streamer.sv
// Merges two key-sorted parent genome streams into aligned gene pairs
// for the EvE_PE crossover engine (parent1/parent2/wr_en producer).
module eve_parent_streamer #(
  parameter int GENE_W     = 64,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_last,
  input  logic [GENE_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_last,
  input  logic [GENE_W-1:0] b_data,
  output logic [GENE_W-1:0] parent1,
  output logic [GENE_W-1:0] parent2,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  matched_cnt,
  output logic [CNT_W-1:0]  disjoint_cnt,
  output logic              order_err
);

  localparam int KEY_W = 17;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_DONE
  } state_t;

  function automatic key_t key_of(input logic [GENE_W-1:0] g);
    key_of = {g[55], g[47:40], g[55] ? g[39:32] : 8'h00};
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic [GENE_W-1:0] a_head;
  logic [GENE_W-1:0] b_head;
  logic              a_hv, a_fin, a_lst, a_pv;
  logic              b_hv, b_fin, b_lst, b_pv;
  key_t              a_pk, b_pk;
  key_t              ka, kb;
  logic [GAP_W-1:0]  gap_cnt;
  logic              gap_end;
  logic              emit, take_a, take_b, match;
  logic              a_hs, b_hs, a_oe, b_oe;
  logic              clr;

  assign ka = key_of(a_head);
  assign kb = key_of(b_head);

  assign a_ready = (state == S_LOAD || state == S_GAP) && !a_hv && !a_fin;
  assign b_ready = (state == S_LOAD || state == S_GAP) && !b_hv && !b_fin;
  assign a_hs    = a_valid && a_ready;
  assign b_hs    = b_valid && b_ready;

  // A freshly loaded key must exceed the last key consumed from its stream.
  assign a_oe = a_hs && a_pv && (key_of(a_data) <= a_pk);
  assign b_oe = b_hs && b_pv && (key_of(b_data) <= b_pk);

  assign clr     = (state == S_IDLE) && start;
  assign gap_end = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign busy    = (state == S_LOAD) || (state == S_GAP);
  assign done    = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    take_a    = 1'b0;
    take_b    = 1'b0;
    match     = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if ((a_hv || a_fin) && (b_hv || b_fin)) begin
          if (a_fin && b_fin) begin
            state_nxt = S_DONE;
          end else begin
            emit = 1'b1;
            if (a_hv && b_hv && ka == kb) begin
              take_a = 1'b1;
              take_b = 1'b1;
              match  = 1'b1;
            end else if ((a_hv && b_hv && ka < kb) || b_fin) begin
              take_a = 1'b1;
            end else begin
              take_b = 1'b1;
            end
            state_nxt = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;
          end
        end
      end
      S_GAP:  if (gap_end) state_nxt = S_LOAD;
      S_DONE: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != S_GAP) gap_cnt <= '0;
      else if (!gap_end)  gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_head <= '0;
      a_hv   <= 1'b0;
      a_fin  <= 1'b0;
      a_lst  <= 1'b0;
      a_pv   <= 1'b0;
      a_pk   <= '0;
    end else if (clr) begin
      a_hv  <= 1'b0;
      a_fin <= 1'b0;
      a_pv  <= 1'b0;
    end else begin
      if (a_hs) begin
        a_head <= a_data;
        a_hv   <= 1'b1;
        a_lst  <= a_last;
      end
      if (take_a) begin
        a_hv <= 1'b0;
        a_pv <= 1'b1;
        a_pk <= ka;
        if (a_lst) a_fin <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_head <= '0;
      b_hv   <= 1'b0;
      b_fin  <= 1'b0;
      b_lst  <= 1'b0;
      b_pv   <= 1'b0;
      b_pk   <= '0;
    end else if (clr) begin
      b_hv  <= 1'b0;
      b_fin <= 1'b0;
      b_pv  <= 1'b0;
    end else begin
      if (b_hs) begin
        b_head <= b_data;
        b_hv   <= 1'b1;
        b_lst  <= b_last;
      end
      if (take_b) begin
        b_hv <= 1'b0;
        b_pv <= 1'b1;
        b_pk <= kb;
        if (b_lst) b_fin <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parent1      <= '0;
      parent2      <= '0;
      wr_en        <= 1'b0;
      matched_cnt  <= '0;
      disjoint_cnt <= '0;
      order_err    <= 1'b0;
    end else begin
      wr_en <= emit;
      if (clr) begin
        matched_cnt  <= '0;
        disjoint_cnt <= '0;
        order_err    <= 1'b0;
      end else begin
        if (a_oe || b_oe) order_err <= 1'b1;
        if (emit) begin
          parent1 <= take_a ? a_head : '0;
          parent2 <= take_b ? b_head : '0;
          if (match) matched_cnt  <= matched_cnt + 1'b1;
          else       disjoint_cnt <= disjoint_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eve_parent_streamer.sv
// Randomized bench for eve_parent_streamer against a key-set merge model.
// Expected pairs come from the union of both streams' keys.
module tb_eve_parent_streamer;

  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        a_valid, a_ready, a_last;
  logic        b_valid, b_ready, b_last;
  logic [63:0] a_data, b_data;
  logic [63:0] parent1, parent2;
  logic        wr_en, busy, done, order_err;
  logic [15:0] matched_cnt, disjoint_cnt;

  eve_parent_streamer #(
    .GENE_W(64),
    .GAP_CYCLES(GAP),
    .CNT_W(16)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_last(a_last),
    .a_data(a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_last(b_last),
    .b_data(b_data),
    .parent1(parent1),
    .parent2(parent2),
    .wr_en(wr_en),
    .busy(busy),
    .done(done),
    .matched_cnt(matched_cnt),
    .disjoint_cnt(disjoint_cnt),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  bit           abort = 0;
  logic [63:0]  sa[$];
  logic [63:0]  sb[$];
  logic [127:0] eq[$];
  logic [127:0] pq[$];
  int           pc[$];
  int           e_match, e_disj;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int key_of(input logic [63:0] g);
    return int'({g[55], g[47:40], g[55] ? g[39:32] : 8'h00});
  endfunction

  function automatic logic [63:0] node(input logic [7:0] id);
    return {8'hC8, 8'h20, id, 8'hF7, $urandom};
  endfunction

  function automatic logic [63:0] conn(input logic [7:0] s,
                                       input logic [7:0] d);
    return {8'hC8, 8'hA0, s, d, $urandom};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      pq.push_back({parent1, parent2});
      pc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      if (pq.size() > 0) check("par_hold", {parent1, parent2}, pq[$]);
    end
  end

  task automatic build_expected();
    logic [63:0] am[int];
    logic [63:0] bm[int];
    bit          ks[int];
    eq.delete();
    e_match = 0;
    e_disj  = 0;
    foreach (sa[i]) begin
      am[key_of(sa[i])] = sa[i];
      ks[key_of(sa[i])] = 1'b1;
    end
    foreach (sb[i]) begin
      bm[key_of(sb[i])] = sb[i];
      ks[key_of(sb[i])] = 1'b1;
    end
    foreach (ks[k]) begin
      if (am.exists(k) && bm.exists(k)) begin
        eq.push_back({am[k], bm[k]});
        e_match++;
      end else if (am.exists(k)) begin
        eq.push_back({am[k], 64'h0});
        e_disj++;
      end else begin
        eq.push_back({64'h0, bm[k]});
        e_disj++;
      end
    end
  endtask

  task automatic gen_rand(input bit to_b, input int nmin);
    logic [63:0] m[int];
    logic [63:0] g;
    int          n;
    n = $urandom_range(nmin, 6);
    while (m.num() < n) begin
      g = {$urandom, $urandom};
      g[55] = 1'($urandom_range(0, 1));
      g[47:40] = 8'($urandom_range(0, g[55] ? 3 : 7));
      if (g[55]) g[39:32] = 8'($urandom_range(0, 3));
      if (!m.exists(key_of(g))) m[key_of(g)] = g;
    end
    if (to_b) sb.delete();
    else      sa.delete();
    foreach (m[k]) begin
      if (to_b) sb.push_back(m[k]);
      else      sa.push_back(m[k]);
    end
  endtask

  task automatic drive(input bit is_b, input int stall, input int delay);
    int idx = 0;
    int n;
    int budget = 0;
    bit hs = 0;
    bit v;
    n = is_b ? sb.size() : sa.size();
    repeat (delay) @(negedge clk);
    while (idx < n) begin
      @(negedge clk);
      if (hs) idx++;
      hs = 0;
      if (idx >= n || abort) break;
      budget++;
      if (budget > 3000) begin
        check(is_b ? "b_drv_timeout" : "a_drv_timeout", 1, 0);
        break;
      end
      v = ($urandom_range(0, 99) >= stall);
      if (is_b) begin
        b_valid = v;
        b_data  = sb[idx];
        b_last  = (idx == n - 1);
        hs      = v && b_ready;
      end else begin
        a_valid = v;
        a_data  = sa[idx];
        a_last  = (idx == n - 1);
        hs      = v && a_ready;
      end
    end
    if (is_b) b_valid = 1'b0;
    else      a_valid = 1'b0;
  endtask

  task automatic run_merge(input string tag, input int stall,
                           input int b_delay, input bit exact_sp,
                           input bit exp_err);
    bit got_done = 0;
    pq.delete();
    pc.delete();
    done_cnt = 0;
    abort    = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 128'(busy), 1);
    check({tag, "_clr_match"}, 128'(matched_cnt), 0);
    fork
      drive(1'b0, stall, 0);
      drive(1'b1, stall, b_delay);
      begin
        if (b_delay > 0) begin
          repeat (b_delay - 1) @(negedge clk);
          check({tag, "_stall_wr"}, 128'(pq.size()), 0);
          check({tag, "_stall_ardy"}, 128'(a_ready), 0);
        end
      end
      begin
        for (int c = 0; c < 4000; c++) begin
          @(negedge clk);
          if (done) begin
            got_done = 1;
            break;
          end
        end
      end
    join
    check({tag, "_done"}, 128'(got_done), 1);
    repeat (2) @(negedge clk);
    check({tag, "_done_cnt"}, 128'(done_cnt), 1);
    check({tag, "_idle_busy"}, 128'(busy), 0);
    check({tag, "_npairs"}, 128'(pq.size()), 128'(eq.size()));
    for (int i = 0; i < pq.size() && i < eq.size(); i++)
      check({tag, "_pair"}, pq[i], eq[i]);
    check({tag, "_matched"}, 128'(matched_cnt), 128'(e_match));
    check({tag, "_disjoint"}, 128'(disjoint_cnt), 128'(e_disj));
    check({tag, "_order_err"}, 128'(order_err), 128'(exp_err));
    for (int i = 1; i < pc.size(); i++) begin
      if (exact_sp) check({tag, "_spacing"}, 128'(pc[i] - pc[i-1]), GAP + 1);
      else check({tag, "_min_gap"}, 128'(pc[i] - pc[i-1] >= GAP + 1), 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_p1"}, parent1, 0);
    check({tag, "_p2"}, parent2, 0);
    check({tag, "_ctl"},
          128'({wr_en, busy, done, order_err, a_ready, b_ready}), 0);
    check({tag, "_cnt"}, 128'({matched_cnt, disjoint_cnt}), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a_valid = 1'b0;
    a_last = 1'b0;
    a_data = '0;
    b_valid = 1'b0;
    b_last = 1'b0;
    b_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;

    sa = '{64'hC82000F722222222, 64'hC82001F733333333};
    sb = '{64'hC92000F611331133, 64'hC92001F622442244};
    build_expected();
    run_merge("aligned", 0, 0, 1'b1, 1'b0);

    sa = '{node(0), node(1), node(3)};
    sb = '{node(0), node(2), node(3), node(4)};
    build_expected();
    run_merge("disjoint", 0, 0, 1'b1, 1'b0);

    sa = '{conn(0, 3), conn(3, 5), conn(4, 7)};
    sb = '{conn(0, 3), conn(3, 5), conn(4, 6)};
    build_expected();
    run_merge("conn", 0, 0, 1'b1, 1'b0);

    gen_rand(1'b0, 2);
    gen_rand(1'b1, 2);
    build_expected();
    run_merge("stall", 0, 6, 1'b1, 1'b0);

    for (int it = 0; it < 25; it++) begin
      gen_rand(1'b0, 1);
      gen_rand(1'b1, 1);
      build_expected();
      run_merge("rand", 30, 0, 1'b0, 1'b0);
    end

    sa = '{node(3), node(1)};
    sb = '{node(5)};
    eq.delete();
    eq.push_back({sa[0], 64'h0});
    eq.push_back({sa[1], 64'h0});
    eq.push_back({64'h0, sb[0]});
    e_match = 0;
    e_disj  = 3;
    run_merge("order", 0, 0, 1'b1, 1'b1);

    gen_rand(1'b0, 3);
    gen_rand(1'b1, 3);
    pq.delete();
    pc.delete();
    done_cnt = 0;
    abort    = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      drive(1'b0, 0, 0);
      drive(1'b1, 0, 0);
      begin
        for (int c = 0; c < 500 && pq.size() == 0; c++) @(negedge clk);
        check("midrst_pulse", 128'(pq.size() > 0), 1);
        rst   = 1'b1;
        abort = 1'b1;
      end
    join
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_done", 128'(done_cnt), 0);
    check("midrst_idle", 128'(busy), 0);
    abort = 1'b0;

    gen_rand(1'b0, 1);
    gen_rand(1'b1, 1);
    build_expected();
    run_merge("after_rst", 0, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
